baby_store_arbiter: RTL and testbench
=====================================

Name: baby_store_arbiter

Overview:
- Shares the single-port main store (32 lines x 32 bits by default) between three users: the CPU fetch/execute path, the front-panel manual-entry port, and a background CRT display scanner.
- Adds a panel "clear store" sequencer that writes zero to every line.
- Sits between the CPU/panel logic and the store instance and drives the store's a/d/we pins.
- Routes the store's registered q back to whichever user issued the read.

Parameters:
- DWIDTH, 32, store word width in bits.
- AWIDTH, 5, store address width in bits; the store has 2^AWIDTH lines.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- mrst_n  in  1  master reset; asynchronous, active-low.
- cpu_req  in  1  CPU access request; held until granted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_a  in  AWIDTH  CPU line address.
- cpu_d  in  DWIDTH  CPU write data.
- cpu_gnt  out  1  combinational; access is performed this cycle.
- cpu_rvalid  out  1  registered; pulses one cycle after a granted CPU read.
- cpu_q  out  DWIDTH  read data; valid when cpu_rvalid=1.
- pnl_req  in  1  panel write request; held until granted.
- pnl_a  in  AWIDTH  panel line address.
- pnl_d  in  DWIDTH  panel write data.
- pnl_gnt  out  1  combinational; panel write performed this cycle.
- pnl_clr  in  1  start a clear-store sweep; level or pulse, sampled in IDLE only.
- clr_busy  out  1  registered; 1 while the sweep is running.
- disp_en  in  1  enables background display scanning.
- disp_valid  out  1  registered; pulses with each scanned line.
- disp_line  out  AWIDTH  index of the scanned line.
- disp_q  out  DWIDTH  contents of the scanned line.
- st_a  out  AWIDTH  store address.
- st_d  out  DWIDTH  store write data.
- st_we  out  1  store write enable.
- st_q  in  DWIDTH  store read data; registered in the store, one cycle after a read.

Behaviour:
- Reset (mrst_n=0, asynchronous):
  - state=IDLE, scan_ptr=0, clr_ptr=0, rd_owner=NONE, last_win=PNL.
  - cpu_rvalid=0, cpu_q=0, disp_valid=0, disp_line=0, disp_q=0, clr_busy=0.
  - st_we, cpu_gnt and pnl_gnt are forced to 0 while mrst_n=0.
- States:
  - IDLE to CLEAR when pnl_clr=1; the transition takes effect at the next edge.
  - CLEAR back to IDLE after the write to line 2^AWIDTH-1.
- CLEAR:
  - Each cycle: st_a=clr_ptr, st_d=0, st_we=1; clr_ptr increments.
  - The sweep takes exactly 2^AWIDTH cycles; clr_busy=1 throughout.
  - cpu_gnt=0, pnl_gnt=0, no display reads; requests stay pending. pnl_clr is ignored.
  - clr_ptr returns to 0 on exit.
- IDLE arbitration (one store access per cycle, decided combinationally):
  - If cpu_req and pnl_req are both set, grant the one not equal to last_win; last_win updates to the winner.
  - If only one requests, grant it; last_win updates.
  - Otherwise, if disp_en=1, issue a display read at scan_ptr. scan_ptr increments and wraps from 2^AWIDTH-1 to 0.
  - Otherwise, idle: st_we=0, st_a=scan_ptr, rd_owner becomes NONE.
- Store pins in IDLE:
  - A CPU grant drives st_a=cpu_a, st_d=cpu_d, st_we=cpu_we.
  - A panel grant drives st_a=pnl_a, st_d=pnl_d, st_we=1.
  - A display read drives st_we=0.
- Read return:
  - rd_owner registers CPU (granted read), DISP (display read) or NONE (write or idle).
  - The next cycle: if CPU, cpu_rvalid=1 and cpu_q=st_q. If DISP, disp_valid=1, disp_q=st_q, and disp_line=the registered address.
  - Latency is one cycle from grant to valid.
  - cpu_q, disp_q and disp_line hold their values when the matching valid is 0.
- Write then read of the same line on consecutive cycles returns the new data; the store is write-through by line.
- The store drives no q on write cycles. The arbiter never asserts rvalid for a write.
- Starvation:
  - CPU vs panel alternation bounds each requester's wait to 1 cycle.
  - The display may starve indefinitely under continuous requests; this is accepted.
- Reset mid-CLEAR aborts the sweep immediately. Lines already cleared stay cleared.

Test Plan:
- Reset, then a CPU write of 0xDEADBEEF to line 3, then a CPU read of line 3 -> cpu_gnt=1 both cycles; cpu_rvalid=1 exactly one cycle after the read grant with cpu_q=0xDEADBEEF.
- cpu_req and pnl_req held together for 4 cycles (the CPU reads line 1, the panel writes line 2) -> grants alternate CPU, PNL, CPU, PNL (CPU first after reset); no simultaneous grants.
- Preload lines 0..31 with their index, disp_en=1 and no requests for 34 cycles -> disp_valid is high every cycle from cycle 1; disp_line runs 0..31 then 0,1 with disp_q=disp_line.
- pnl_clr pulse with cpu_req held -> clr_busy=1 for 32 cycles with 32 zero writes at addresses 0..31; cpu_gnt=0 throughout and asserts on the first cycle after clr_busy falls. A subsequent scan shows all lines 0.
- mrst_n asserted at clear cycle 10 -> clr_busy=0 and st_we=0 immediately. Lines 0..9 read 0 and lines 10..31 keep their old values after release.
- CPU read grant on the same cycle as disp_en=1 -> the display read is deferred one cycle. cpu_rvalid and disp_valid never route each other's data.

Source files
------------

// File: rtl/baby_store_arbiter.sv
// baby_store_arbiter: shares the single-port main store between the CPU,
// the front-panel entry port and the CRT display scanner, and runs the
// panel clear-store sweep. Read data returns one cycle after the grant.
module baby_store_arbiter #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              mrst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AWIDTH-1:0] cpu_a,
  input  logic [DWIDTH-1:0] cpu_d,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DWIDTH-1:0] cpu_q,
  input  logic              pnl_req,
  input  logic [AWIDTH-1:0] pnl_a,
  input  logic [DWIDTH-1:0] pnl_d,
  output logic              pnl_gnt,
  input  logic              pnl_clr,
  output logic              clr_busy,
  input  logic              disp_en,
  output logic              disp_valid,
  output logic [AWIDTH-1:0] disp_line,
  output logic [DWIDTH-1:0] disp_q,
  output logic [AWIDTH-1:0] st_a,
  output logic [DWIDTH-1:0] st_d,
  output logic              st_we,
  input  logic [DWIDTH-1:0] st_q
);

  typedef enum logic {IDLE, CLEAR} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DISP} owner_t;
  typedef enum logic {WIN_CPU, WIN_PNL} win_t;

  localparam logic [AWIDTH-1:0] LAST_LINE = '1;
  localparam logic [AWIDTH-1:0] ONE       = {{(AWIDTH-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  owner_t            rd_owner, rd_owner_nxt;
  win_t              last_win, last_win_nxt;
  logic [AWIDTH-1:0] scan_ptr, scan_ptr_nxt;
  logic [AWIDTH-1:0] clr_ptr, clr_ptr_nxt;
  logic              cpu_gnt_raw, pnl_gnt_raw, st_we_raw, disp_rd;
  logic [DWIDTH-1:0] cpu_q_hold, disp_q_hold;

  // Decide this cycle's single store access and the next-state values.
  always_comb begin
    state_nxt    = state;
    rd_owner_nxt = OWN_NONE;
    last_win_nxt = last_win;
    scan_ptr_nxt = scan_ptr;
    clr_ptr_nxt  = clr_ptr;
    cpu_gnt_raw  = 1'b0;
    pnl_gnt_raw  = 1'b0;
    st_we_raw    = 1'b0;
    disp_rd      = 1'b0;
    st_a         = scan_ptr;
    st_d         = '0;
    case (state)
      CLEAR: begin
        st_a      = clr_ptr;
        st_we_raw = 1'b1;
        if (clr_ptr == LAST_LINE) begin
          state_nxt   = IDLE;
          clr_ptr_nxt = '0;
        end else begin
          clr_ptr_nxt = clr_ptr + ONE;
        end
      end
      default: begin
        if (pnl_clr) state_nxt = CLEAR;
        if (cpu_req && (!pnl_req || last_win == WIN_PNL)) begin
          cpu_gnt_raw  = 1'b1;
          st_a         = cpu_a;
          st_d         = cpu_d;
          st_we_raw    = cpu_we;
          last_win_nxt = WIN_CPU;
          rd_owner_nxt = cpu_we ? OWN_NONE : OWN_CPU;
        end else if (pnl_req) begin
          pnl_gnt_raw  = 1'b1;
          st_a         = pnl_a;
          st_d         = pnl_d;
          st_we_raw    = 1'b1;
          last_win_nxt = WIN_PNL;
        end else if (disp_en) begin
          disp_rd      = 1'b1;
          rd_owner_nxt = OWN_DISP;
          scan_ptr_nxt = scan_ptr + ONE;
        end
      end
    endcase
  end

  // Grants and the store write strobe are held off while reset is asserted.
  assign cpu_gnt = cpu_gnt_raw & mrst_n;
  assign pnl_gnt = pnl_gnt_raw & mrst_n;
  assign st_we   = st_we_raw & mrst_n;

  assign clr_busy   = (state == CLEAR);
  assign cpu_rvalid = (rd_owner == OWN_CPU);
  assign disp_valid = (rd_owner == OWN_DISP);
  assign cpu_q      = cpu_rvalid ? st_q : cpu_q_hold;
  assign disp_q     = disp_valid ? st_q : disp_q_hold;

  // Arbiter state, pointers and read-owner tag.
  always_ff @(posedge clk or negedge mrst_n) begin
    if (!mrst_n) begin
      state     <= IDLE;
      rd_owner  <= OWN_NONE;
      last_win  <= WIN_PNL;
      scan_ptr  <= '0;
      clr_ptr   <= '0;
      disp_line <= '0;
    end else begin
      state    <= state_nxt;
      rd_owner <= rd_owner_nxt;
      last_win <= last_win_nxt;
      scan_ptr <= scan_ptr_nxt;
      clr_ptr  <= clr_ptr_nxt;
      if (disp_rd) disp_line <= scan_ptr;
    end
  end

  // Keep the last returned words so cpu_q/disp_q hold between valid pulses.
  always_ff @(posedge clk or negedge mrst_n) begin
    if (!mrst_n) begin
      cpu_q_hold  <= '0;
      disp_q_hold <= '0;
    end else begin
      if (cpu_rvalid) cpu_q_hold <= st_q;
      if (disp_valid) disp_q_hold <= st_q;
    end
  end

endmodule

// File: tb/tb_baby_store_arbiter.sv
// Testbench for baby_store_arbiter: a registered store model on the st_*
// pins, a reference image of store contents kept by the bench, and
// scoreboard queues for CPU and display read returns.
module tb_baby_store_arbiter;

  logic        clk = 1'b0;
  logic        mrst_n;
  logic        cpu_req, cpu_we, pnl_req, pnl_clr, disp_en;
  logic [4:0]  cpu_a, pnl_a;
  logic [31:0] cpu_d, pnl_d;
  logic        cpu_gnt, cpu_rvalid, pnl_gnt, clr_busy, disp_valid, st_we;
  logic [31:0] cpu_q, disp_q, st_d, st_q;
  logic [4:0]  disp_line, st_a;

  logic [31:0] st_mem  [32];
  logic [31:0] ref_mem [32];
  logic [31:0] cpu_exp_q [$];
  logic [36:0] disp_exp_q [$];
  logic [4:0]  exp_scan;
  int          n_cmp = 0;
  int          n_bad = 0;

  baby_store_arbiter dut (
    .clk(clk), .mrst_n(mrst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_d(cpu_d),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_q(cpu_q),
    .pnl_req(pnl_req), .pnl_a(pnl_a), .pnl_d(pnl_d), .pnl_gnt(pnl_gnt),
    .pnl_clr(pnl_clr), .clr_busy(clr_busy),
    .disp_en(disp_en), .disp_valid(disp_valid), .disp_line(disp_line), .disp_q(disp_q),
    .st_a(st_a), .st_d(st_d), .st_we(st_we), .st_q(st_q)
  );

  always #5 clk = ~clk;

  // Single-port store: write on we, otherwise registered read.
  always @(posedge clk) begin
    if (st_we) st_mem[st_a] <= st_d;
    else       st_q <= st_mem[st_a];
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_a = '0; cpu_d = '0;
    pnl_req = 1'b0; pnl_a = '0; pnl_d = '0; pnl_clr = 1'b0; disp_en = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    mrst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 mrst_n = 1'b1;
    exp_scan = '0;
    cpu_exp_q.delete();
    disp_exp_q.delete();
  endtask

  // Scan n display lines with no competing requests, checking each return.
  task automatic scan_lines(input int n);
    logic [36:0] e;
    for (int k = 0; k <= n; k++) begin
      @(posedge clk); #1;
      disp_en = (k < n);
      if (k < n) begin
        disp_exp_q.push_back({exp_scan, ref_mem[exp_scan]});
        exp_scan = exp_scan + 5'd1;
      end
      @(negedge clk);
      n_cmp++;
      if (disp_valid !== (k >= 1)) begin
        n_bad++; $display("[TB] FAIL scan_valid k=%0d: got %b want %b", k, disp_valid, (k >= 1));
      end
      if (disp_valid === 1'b1) begin
        n_cmp++;
        if (disp_exp_q.size() == 0) begin
          n_bad++; $display("[TB] FAIL scan_extra: unexpected disp_valid line=%0d", disp_line);
        end else begin
          e = disp_exp_q.pop_front();
          if ({disp_line, disp_q} !== e) begin
            n_bad++; $display("[TB] FAIL scan_data: got line %0d q %h want line %0d q %h", disp_line, disp_q, e[36:32], e[31:0]);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    mrst_n = 1'b0;
    clear_inputs();
    cpu_req = 1'b1; cpu_we = 1'b1; pnl_req = 1'b1; pnl_clr = 1'b1; disp_en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({cpu_gnt, pnl_gnt, st_we} !== 3'b000) begin
      n_bad++; $display("[TB] FAIL rst_gnt_we: got %b want 000", {cpu_gnt, pnl_gnt, st_we});
    end
    n_cmp++;
    if ({cpu_rvalid, disp_valid, clr_busy} !== 3'b000) begin
      n_bad++; $display("[TB] FAIL rst_flags: got %b want 000", {cpu_rvalid, disp_valid, clr_busy});
    end
    n_cmp++;
    if ({cpu_q, disp_q, disp_line} !== '0) begin
      n_bad++; $display("[TB] FAIL rst_data: got cpu_q %h disp_q %h line %0d want 0", cpu_q, disp_q, disp_line);
    end
    clear_inputs();
    @(posedge clk); #1 mrst_n = 1'b1;
    exp_scan = '0;
  endtask

  task automatic test_cpu_write_read();
    logic [31:0] e;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 5'd3; cpu_d = 32'hDEADBEEF;
    ref_mem[3] = 32'hDEADBEEF;
    @(negedge clk);
    n_cmp++;
    if ({cpu_gnt, st_we, st_a, st_d} !== {1'b1, 1'b1, 5'd3, 32'hDEADBEEF}) begin
      n_bad++; $display("[TB] FAIL wr_pins: got gnt %b we %b a %0d d %h want 1 1 3 deadbeef", cpu_gnt, st_we, st_a, st_d);
    end
    @(posedge clk); #1;
    cpu_we = 1'b0;
    cpu_exp_q.push_back(ref_mem[3]);
    @(negedge clk);
    n_cmp++;
    if ({cpu_gnt, cpu_rvalid, st_we} !== 3'b100) begin
      n_bad++; $display("[TB] FAIL rd_grant: got gnt/rvalid/we %b want 100", {cpu_gnt, cpu_rvalid, st_we});
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cpu_rvalid !== 1'b1) begin
      n_bad++; $display("[TB] FAIL rd_rvalid: got %b want 1", cpu_rvalid);
    end else begin
      e = cpu_exp_q.pop_front();
      n_cmp++;
      if (cpu_q !== e) begin
        n_bad++; $display("[TB] FAIL rd_data: got %h want %h", cpu_q, e);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({cpu_rvalid, cpu_q} !== {1'b0, 32'hDEADBEEF}) begin
      n_bad++; $display("[TB] FAIL rd_hold: got rvalid %b q %h want 0 deadbeef", cpu_rvalid, cpu_q);
    end
  endtask

  task automatic test_display_scan();
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      pnl_req = 1'b1; pnl_a = 5'(i); pnl_d = 32'(i);
      ref_mem[i] = 32'(i);
      @(negedge clk);
      n_cmp++;
      if ({pnl_gnt, cpu_gnt, st_we, st_a} !== {1'b1, 1'b0, 1'b1, 5'(i)}) begin
        n_bad++; $display("[TB] FAIL preload %0d: got pnl %b cpu %b we %b a %0d", i, pnl_gnt, cpu_gnt, st_we, st_a);
      end
    end
    @(posedge clk); #1;
    pnl_req = 1'b0;
    scan_lines(34);
  endtask

  task automatic test_alternation();
    logic exp_cpu;
    logic [31:0] e;
    do_reset();
    for (int k = 0; k <= 4; k++) begin
      @(posedge clk); #1;
      exp_cpu = (k % 2 == 0);
      if (k < 4) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 5'd1;
        pnl_req = 1'b1; pnl_a = 5'd2; pnl_d = 32'h22222222;
        if (exp_cpu) cpu_exp_q.push_back(ref_mem[1]);
        else         ref_mem[2] = 32'h22222222;
      end else begin
        cpu_req = 1'b0; pnl_req = 1'b0;
      end
      @(negedge clk);
      if (k < 4) begin
        n_cmp++;
        if ({cpu_gnt, pnl_gnt} !== {exp_cpu, !exp_cpu}) begin
          n_bad++; $display("[TB] FAIL alt_grant k=%0d: got cpu %b pnl %b want %b %b", k, cpu_gnt, pnl_gnt, exp_cpu, !exp_cpu);
        end
      end
      n_cmp++;
      if (cpu_rvalid !== (k >= 1 && (k - 1) % 2 == 0)) begin
        n_bad++; $display("[TB] FAIL alt_rvalid k=%0d: got %b", k, cpu_rvalid);
      end
      if (cpu_rvalid === 1'b1 && cpu_exp_q.size() != 0) begin
        e = cpu_exp_q.pop_front();
        n_cmp++;
        if (cpu_q !== e) begin
          n_bad++; $display("[TB] FAIL alt_data k=%0d: got %h want %h", k, cpu_q, e);
        end
      end
    end
  endtask

  task automatic test_clear();
    logic [31:0] e;
    for (int k = 0; k <= 34; k++) begin
      @(posedge clk); #1;
      pnl_clr = (k == 0);
      cpu_req = (k >= 1 && k <= 33); cpu_we = 1'b0; cpu_a = 5'd5;
      if (k == 1) for (int i = 0; i < 32; i++) ref_mem[i] = '0;
      if (k == 33) cpu_exp_q.push_back(ref_mem[5]);
      @(negedge clk);
      if (k == 0) begin
        n_cmp++;
        if (clr_busy !== 1'b0) begin
          n_bad++; $display("[TB] FAIL clr_start: got busy %b want 0", clr_busy);
        end
      end else if (k <= 32) begin
        n_cmp++;
        if ({clr_busy, cpu_gnt, pnl_gnt, st_we, st_a, st_d} !== {4'b1001, 5'(k - 1), 32'h0}) begin
          n_bad++; $display("[TB] FAIL clr_cycle %0d: got busy %b cpu %b pnl %b we %b a %0d d %h", k - 1, clr_busy, cpu_gnt, pnl_gnt, st_we, st_a, st_d);
        end
      end else if (k == 33) begin
        n_cmp++;
        if ({clr_busy, cpu_gnt} !== 2'b01) begin
          n_bad++; $display("[TB] FAIL clr_exit: got busy %b gnt %b want 0 1", clr_busy, cpu_gnt);
        end
      end else begin
        n_cmp++;
        if (cpu_rvalid !== 1'b1 || cpu_exp_q.size() == 0) begin
          n_bad++; $display("[TB] FAIL clr_rvalid: got %b want 1", cpu_rvalid);
        end else begin
          e = cpu_exp_q.pop_front();
          n_cmp++;
          if (cpu_q !== e) begin
            n_bad++; $display("[TB] FAIL clr_rdata: got %h want %h", cpu_q, e);
          end
        end
      end
    end
    scan_lines(32);
  endtask

  task automatic test_reset_mid_clear();
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      pnl_req = 1'b1; pnl_a = 5'(i); pnl_d = 32'hA5000000 | 32'(i);
      ref_mem[i] = 32'hA5000000 | 32'(i);
    end
    @(posedge clk); #1;
    pnl_req = 1'b0; pnl_clr = 1'b1;
    @(posedge clk); #1;
    pnl_clr = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if ({clr_busy, st_we, st_a} !== {1'b1, 1'b1, 5'd10}) begin
      n_bad++; $display("[TB] FAIL abort_pre: got busy %b we %b a %0d want 1 1 10", clr_busy, st_we, st_a);
    end
    #1 mrst_n = 1'b0;
    #1;
    n_cmp++;
    if ({clr_busy, st_we} !== 2'b00) begin
      n_bad++; $display("[TB] FAIL abort_now: got busy %b we %b want 0 0", clr_busy, st_we);
    end
    for (int i = 0; i < 10; i++) ref_mem[i] = '0;
    repeat (2) @(posedge clk);
    #1 mrst_n = 1'b1;
    exp_scan = '0;
    scan_lines(32);
  endtask

  task automatic test_cpu_vs_disp();
    logic [31:0] e;
    logic [36:0] d;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 5'd12; disp_en = 1'b1;
    cpu_exp_q.push_back(ref_mem[12]);
    @(negedge clk);
    n_cmp++;
    if ({cpu_gnt, st_we, st_a} !== {1'b1, 1'b0, 5'd12}) begin
      n_bad++; $display("[TB] FAIL cvd_grant: got gnt %b we %b a %0d want 1 0 12", cpu_gnt, st_we, st_a);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    disp_exp_q.push_back({exp_scan, ref_mem[exp_scan]});
    exp_scan = exp_scan + 5'd1;
    @(negedge clk);
    n_cmp++;
    if ({cpu_rvalid, disp_valid} !== 2'b10) begin
      n_bad++; $display("[TB] FAIL cvd_valid1: got cpu %b disp %b want 1 0", cpu_rvalid, disp_valid);
    end
    e = cpu_exp_q.pop_front();
    n_cmp++;
    if (cpu_q !== e) begin
      n_bad++; $display("[TB] FAIL cvd_cpu_q: got %h want %h", cpu_q, e);
    end
    @(posedge clk); #1;
    disp_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cpu_rvalid, disp_valid, cpu_q} !== {2'b01, e}) begin
      n_bad++; $display("[TB] FAIL cvd_valid2: got cpu %b disp %b cpu_q %h want 0 1 %h", cpu_rvalid, disp_valid, cpu_q, e);
    end
    d = disp_exp_q.pop_front();
    n_cmp++;
    if ({disp_line, disp_q} !== d) begin
      n_bad++; $display("[TB] FAIL cvd_disp: got line %0d q %h want line %0d q %h", disp_line, disp_q, d[36:32], d[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_write_read();
    test_display_scan();
    test_alternation();
    test_clear();
    test_reset_mid_clear();
    test_cpu_vs_disp();
    n_cmp++;
    if (cpu_exp_q.size() != 0 || disp_exp_q.size() != 0) begin
      n_bad++; $display("[TB] FAIL leftover: cpu %0d disp %0d expected returns never arrived", cpu_exp_q.size(), disp_exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
